// File: rtl/bv4_mul_seq.sv
// bv4_mul_seq: multi-cycle GF(2^4) multiplier for the tower-field S-box.
// GF(2^4) = GF(2^2)[Y]/(Y^2+Y+N), N = 2'b10, GF(2^2) in normal basis (one = 2'b11).
// One shared bv2_mul is time-multiplexed over the Karatsuba partials
// p = ah*bh, q = al*bl, r = (ah^al)*(bh^bl); ch = r^q, cl = p*N ^ q.
//
// Ports:
//   in_clk     clock, rising edge
//   in_rst_n   asynchronous active-low reset
//   in_valid   operand pair on in_a/in_b is valid
//   out_ready  block accepts operands this cycle (driven by the block)
//   in_a/in_b  GF(2^4) operands {hi[1:0], lo[1:0]}
//   out_valid  out_c holds a finished product
//   in_ready   consumer accepts out_c this cycle
//   out_c      product {ch, cl}
//
// state | meaning
// IDLE  | waiting for operands, out_ready=1
// S_P   | p = ah*bh on the shared multiplier
// S_Q   | q = al*bl on the shared multiplier
// S_R   | r = (ah^al)*(bh^bl), assemble product into out_c
// DONE  | out_valid=1, hold until consumer takes it

module bv2_mul (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [1:0] c_o
);
    logic e;

    // Normal-basis GF(2^2) product; the shared term e couples both bits.
    assign e      = (a_i[1] ^ a_i[0]) & (b_i[1] ^ b_i[0]);
    assign c_o[1] = (a_i[1] & b_i[1]) ^ e;
    assign c_o[0] = (a_i[0] & b_i[0]) ^ e;
endmodule

module bv4_mul_seq (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_valid,
    output logic       out_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       in_ready,
    output logic [3:0] out_c
);
    typedef enum logic [2:0] {IDLE, S_P, S_Q, S_R, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] opa_q, opb_q;
    logic [1:0] p_q, q_q;
    logic [3:0] c_q;
    logic [1:0] mul_a, mul_b, mul_c;
    logic [1:0] p_scaled;
    logic       accept;

    bv2_mul u_mul (
        .a_i(mul_a),
        .b_i(mul_b),
        .c_o(mul_c)
    );

    assign out_ready = (state_q == IDLE) | ((state_q == DONE) & in_ready);
    assign out_valid = (state_q == DONE);
    assign out_c     = c_q;
    assign accept    = in_valid & out_ready;

    // p*N without a multiplier.
    assign p_scaled  = {p_q[0], p_q[0] ^ p_q[1]};

    always_comb begin
        state_d = state_q;
        mul_a   = 2'b00;
        mul_b   = 2'b00;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = S_P;
            end
            S_P: begin
                mul_a   = opa_q[3:2];
                mul_b   = opb_q[3:2];
                state_d = S_Q;
            end
            S_Q: begin
                mul_a   = opa_q[1:0];
                mul_b   = opb_q[1:0];
                state_d = S_R;
            end
            S_R: begin
                mul_a   = opa_q[3:2] ^ opa_q[1:0];
                mul_b   = opb_q[3:2] ^ opb_q[1:0];
                state_d = DONE;
            end
            DONE: begin
                if (in_ready) state_d = in_valid ? S_P : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            opa_q   <= 4'b0000;
            opb_q   <= 4'b0000;
            p_q     <= 2'b00;
            q_q     <= 2'b00;
            c_q     <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opa_q <= in_a;
                opb_q <= in_b;
            end
            if (state_q == S_P) p_q <= mul_c;
            if (state_q == S_Q) q_q <= mul_c;
            // r is used straight off the multiplier; only the product is stored.
            if (state_q == S_R) c_q <= {mul_c ^ q_q, p_scaled ^ q_q};
        end
    end
endmodule

// File: tb/tb_bv4_mul_seq.sv
module tb_bv4_mul_seq;
    logic       in_clk = 1'b0;
    logic       in_rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready;
    logic [3:0] in_a = 4'h0;
    logic [3:0] in_b = 4'h0;
    logic       out_valid;
    logic       in_ready = 1'b0;
    logic [3:0] out_c;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] res [256];
    int         errors = 0;
    int         checks = 0;
    logic       rand_rdy = 1'b0;

    bv4_mul_seq dut (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .in_ready (in_ready),
        .out_c    (out_c)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // GF(2^2) normal basis as a table: 11=1, 01=W, 10=W^2, W^3=1.
    function automatic logic [1:0] m2(input logic [1:0] x, input logic [1:0] y);
        if (x == 2'b00 || y == 2'b00) return 2'b00;
        if (x == 2'b11) return y;
        if (y == 2'b11) return x;
        if (x == y) return (x == 2'b01) ? 2'b10 : 2'b01;
        return 2'b11;
    endfunction

    // Schoolbook product with Y^2 = Y + N.
    function automatic logic [3:0] m4(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh, ch, cl;
        hh = m2(a[3:2], b[3:2]);
        ch = m2(a[3:2], b[1:0]) ^ m2(a[1:0], b[3:2]) ^ hh;
        cl = m2(a[1:0], b[1:0]) ^ m2(hh, 2'b10);
        return {ch, cl};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge in_clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after acceptance.
    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int n;
        n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge in_clk);
        while (!out_ready && n < 60) begin
            @(negedge in_clk);
            n++;
        end
        if (!out_ready) chk("send_timeout", 32'd1, 32'd0);
        @(posedge in_clk);
        #1;
        in_valid = 1'b0;
        in_a = 4'($urandom);
        in_b = 4'($urandom);
    endtask

    // Counts negedges until out_valid; handshake cycle is offset 0.
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge in_clk);
            n++;
        end while (!out_valid && n < 40);
    endtask

    initial begin
        int         n;
        logic [3:0] c0;
        logic [15:0] vmask;
        int         stale;

        fork
            forever begin
                @(negedge in_clk);
                if (in_rst_n) begin
                    if (out_valid && in_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_out", {28'd0, out_c}, 32'hFFFF_FFFF);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            res[{e.a, e.b}] = out_c;
                            chk($sformatf("sb_%h_%h", e.a, e.b), {28'd0, out_c}, {28'd0, e.c});
                        end
                    end
                    if (in_valid && out_ready) exp_q.push_back('{in_a, in_b, m4(in_a, in_b)});
                end
            end
            forever begin
                @(posedge in_clk);
                #1;
                if (rand_rdy) in_ready = 1'($urandom_range(0, 1));
            end
        join_none

        // Reset state
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", out_ready, 1);
        chk("rst_c", out_c, 0);
        @(negedge in_clk);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        cyc(1);
        in_ready = 1'b1;

        // Identity and latency
        send(4'b0011, 4'b1001);
        wait_out(n);
        chk("lat_identity", n, 4);
        chk("identity", out_c, 4'b1001);
        cyc(1);
        send(4'b1001, 4'b0011);
        wait_out(n);
        chk("lat_swap", n, 4);
        chk("identity_swap", out_c, 4'b1001);
        cyc(1);
        send(4'b1100, 4'b1100);
        wait_out(n);
        chk("yy", out_c, 4'b1110);
        cyc(1);
        send(4'h0, 4'hF);
        wait_out(n);
        chk("zero", out_c, 4'h0);
        cyc(1);

        // Back-pressure with operand toggling
        in_ready = 1'b0;
        send(4'h5, 4'h7);
        wait_out(n);
        c0 = m4(4'h5, 4'h7);
        chk("bp_first", out_c, c0);
        for (int i = 0; i < 10; i++) begin
            @(posedge in_clk);
            #1;
            in_valid = 1'b1;
            in_a = 4'($urandom);
            in_b = 4'($urandom);
            @(negedge in_clk);
            chk("bp_c", out_c, c0);
            chk("bp_ready", out_ready, 0);
            chk("bp_valid", out_valid, 1);
        end
        @(posedge in_clk);
        #1;
        in_valid = 1'b0;
        in_ready = 1'b1;
        cyc(2);
        chk("bp_idle", out_valid, 0);

        // Back-to-back: products at offsets 4, 8, 12
        vmask = '0;
        for (int i = 0; i < 15; i++) begin
            if (i == 0) begin in_valid = 1'b1; in_a = 4'h6; in_b = 4'hB; end
            if (i == 1) begin in_a = 4'hD; in_b = 4'h2; end
            if (i == 5) begin in_a = 4'h7; in_b = 4'h7; end
            if (i == 9) in_valid = 1'b0;
            @(negedge in_clk);
            if (out_valid) vmask[i] = 1'b1;
            @(posedge in_clk);
            #1;
        end
        chk("b2b_mask", {16'd0, vmask}, 32'h0000_1110);

        // Reset during S_Q discards the product
        send(4'h7, 4'hB);
        @(posedge in_clk);
        #2;
        in_rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", out_ready, 1);
        chk("midrst_c", out_c, 0);
        exp_q.delete();
        @(negedge in_clk);
        in_rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge in_clk);
            if (out_valid) stale++;
        end
        chk("no_stale", stale, 0);
        cyc(1);

        // Exhaustive with random stalls
        rand_rdy = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                cyc($urandom_range(0, 2));
                send(4'(a), 4'(b));
            end
        end
        rand_rdy = 1'b0;
        @(posedge in_clk);
        #2;
        in_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge in_clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        for (int a = 0; a < 16; a++) begin
            for (int b = a + 1; b < 16; b++) begin
                chk($sformatf("commute_%h_%h", a, b), {28'd0, res[{4'(a), 4'(b)}]},
                    {28'd0, res[{4'(b), 4'(a)}]});
            end
        end
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
